// File: rtl/cmd_pkg.sv
// Opcodes, response codes and FSM states shared by the command stage, its bench and the CommMaster stimulus.
// Pure declarations; no latency or backpressure of its own.
package cmd_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [1:0] {IDLE, SPINUP, CAL, RESP} state_t;

endpackage

// File: rtl/spinup_tmr.sv
// Motor spin-up timer: clr zeroes, en counts; tc is high while enabled at the all-ones count.
// tc is combinational off the count register; no backpressure.
module spinup_tmr #(
  parameter int BITS = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [BITS-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tc = en & (&cnt);

endmodule

// File: rtl/cmd_cfg.sv
// Decodes wrapper frames into setpoints, sequences spin-up/calibration and returns one response byte.
// Results one clock after decode; a frame is held by the wrapper until the FSM is back in IDLE.
module cmd_cfg
  import cmd_pkg::*;
#(
  parameter int         SPINUP_BITS = 26,
  parameter logic [7:0] ACK         = ACK_BYTE,
  parameter logic [7:0] ERR         = ERR_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        resp_sent,
  input  logic [7:0]  batt,
  input  logic        cal_done,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst,
  output logic        strt_cal,
  output logic        inert_cal,
  output logic        motors_off
);

  state_t state;
  logic   tmr_clr;
  logic   tmr_en;
  logic   tmr_tc;

  assign tmr_clr = (state == IDLE) && cmd_rdy && (cmd == CALIBRATE);
  assign tmr_en  = (state == SPINUP);

  spinup_tmr #(.BITS(SPINUP_BITS)) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      d_ptch      <= '0;
      d_roll      <= '0;
      d_yaw       <= '0;
      thrst       <= '0;
      motors_off  <= 1'b1;
      resp        <= '0;
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      strt_cal    <= 1'b0;
      inert_cal   <= 1'b0;
    end else begin
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      strt_cal    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_rdy) begin
            clr_cmd_rdy <= 1'b1;
            if (cmd == CALIBRATE) begin
              // Response is deferred until the inertial unit reports completion.
              motors_off <= 1'b0;
              inert_cal  <= 1'b1;
              state      <= SPINUP;
            end else begin
              send_resp <= 1'b1;
              resp      <= ACK;
              state     <= RESP;
              case (cmd)
                REQ_BATT:  resp <= batt;
                SET_PTCH:  d_ptch <= data;
                SET_ROLL:  d_roll <= data;
                SET_YAW:   d_yaw <= data;
                SET_THRST: thrst <= data[8:0];
                EMER_LAND: begin
                  d_ptch <= '0;
                  d_roll <= '0;
                  d_yaw  <= '0;
                  thrst  <= '0;
                end
                MTRS_OFF:  motors_off <= 1'b1;
                default:   resp <= ERR;
              endcase
            end
          end
        end
        SPINUP: begin
          if (tmr_tc) begin
            strt_cal <= 1'b1;
            state    <= CAL;
          end
        end
        CAL: begin
          if (cal_done) begin
            inert_cal <= 1'b0;
            resp      <= ACK;
            send_resp <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (resp_sent)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
